tone_player: RTL and testbench
==============================

// Module: tone_player
// PURPOSE
//  Consumes the slow toggling beat clock produced by clockDivider and plays a fixed
//  8-step melody on a 1-bit speaker output, one note per beat. Synchronises the beat
//  clock into the in_clock domain, turns its rising edges into single-cycle beat events,
//  steps a note sequencer on each event and generates each note's square wave.
//  Sits between clockDivider and the board speaker/PMOD pin in the snake sound path.
// PARAMETERS
//  SYNC_STAGES  2   flops in the in_beat_clock synchroniser (>=2)
//  HALF_W       17  width of the half-period counter / note ROM entries
//  LAST_NOTE    7   index of final melody step (ROM depth = LAST_NOTE+1)
// PORTS
//  in_clock      in   1  100 MHz system clock; all state on its rising edge
//  in_reset_n    in   1  asynchronous, active-low reset
//  in_beat_clock in   1  slow toggling beat clock (clockDivider output), asynchronous
//  in_start      in   1  level; starts the melody when idle
//  in_stop       in   1  level; aborts playback
//  out_speaker   out  1  square-wave audio
//  out_busy      out  1  high in WAIT_BEAT and PLAY
//  out_note_idx  out  3  current melody step
//  out_done      out  1  one-cycle pulse on melody completion
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchroniser, edge-detect flop and counters 0.
//  Beat event: rising edge of the last synchroniser stage vs. its delayed copy; 1 cycle wide.
//   Latency: clock edge first sampling in_beat_clock=1 -> beat event asserted 2 edges later
//   (SYNC_STAGES=2); state/idx updates on the following edge.
//  Note ROM (half-period in in_clock cycles, 0 = rest):
//   0:95556 (C5) 1:75843 (E5) 2:63776 (G5) 3:0 4:63776 5:75843 6:95556 7:0
//  FSM:
//   IDLE      : in_start & ~in_stop -> WAIT_BEAT. Beat events ignored.
//   WAIT_BEAT : beat -> PLAY, idx<=0, tone counter<=0, speaker<=0.
//   PLAY      : beat & idx<LAST_NOTE -> idx<=idx+1, counter<=0, speaker<=0.
//               beat & idx==LAST_NOTE -> DONE.
//   DONE      : out_done=1 for this single cycle, speaker<=0, idx<=0 -> IDLE.
//  Tone gen (PLAY only): half=ROM[idx]. half==0 -> speaker held 0, counter held 0.
//   Else counter increments each cycle; when counter==half-1: speaker toggles, counter<=0.
//   Full period = 2*half cycles. Outside PLAY speaker=0, counter=0.
//  in_stop (any state, checked first): next edge -> IDLE, speaker 0, idx 0, counter 0,
//   no out_done. in_start & in_stop same cycle: stop wins.
//  in_start while busy: ignored (no restart). Held in_start after DONE re-arms in IDLE.
//  Beat event and in_stop same cycle: stop wins. Async reset mid-note: immediate reset
//   values, no glitch beyond clearing speaker.
//  out_busy = (state==WAIT_BEAT)|(state==PLAY), registered with state.
// CONFIGURATION
//  TONE_PLAYER_LOOP_EN defined: beat at idx==LAST_NOTE wraps idx<=0, counter<=0,
//   speaker<=0, pulses out_done for that cycle and stays in PLAY; only in_stop/reset end
//   playback. DONE state unused.
//  Not defined: single-shot via DONE -> IDLE as above.
// TESTING
//  1 Reset: in_reset_n=0 mid-PLAY -> speaker/busy/done/idx all 0 immediately, state IDLE.
//  2 Start + first beat: in_start 1 cycle, beat rises -> busy=1, idx=0 3 edges after
//    beat sampled; speaker toggles every 95556 cycles (period 191112).
//  3 Rest: advance to idx=3 -> speaker stays 0 for whole beat; idx=4 -> toggles every 63776.
//  4 Completion: 8 beats after WAIT_BEAT -> out_done high exactly 1 cycle, then busy=0, idx=0;
//    further beats leave speaker 0. With TONE_PLAYER_LOOP_EN: idx wraps 7->0, done 1 cycle, busy stays 1.
//  5 Abort/priority: in_stop=1 with beat event same cycle at idx=2 -> IDLE, idx=0, no out_done;
//    in_start & in_stop together in IDLE -> stays IDLE.
//  6 Start while busy at idx=5 -> no effect, idx continues 6 on next beat.

Source files
------------

// File: rtl/tone_player_if.sv
// tone_player_if: beat/control inputs and audio/status outputs of the tone player.
interface tone_player_if;
  logic       in_beat_clock;
  logic       in_start;
  logic       in_stop;
  logic       out_speaker;
  logic       out_busy;
  logic [2:0] out_note_idx;
  logic       out_done;
  modport master (
    output in_beat_clock, in_start, in_stop,
    input  out_speaker, out_busy, out_note_idx, out_done
  );
  modport slave (
    input  in_beat_clock, in_start, in_stop,
    output out_speaker, out_busy, out_note_idx, out_done
  );
endinterface

// File: rtl/tone_player.sv
// tone_player: plays a fixed 8-step melody on a square-wave speaker, one note per beat.
// Define TONE_PLAYER_LOOP_EN to loop the melody forever instead of stopping after the last note.
module tone_player #(
  parameter int SYNC_STAGES = 2,
  parameter int HALF_W      = 17,
  parameter int LAST_NOTE   = 7
) (
  input  logic          in_clock,
  input  logic          in_reset_n,
  tone_player_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT_BEAT, PLAY, DONE} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q, beat_q;
  logic [2:0]             idx_q, idx_d;
  logic [HALF_W-1:0]      cnt_q, cnt_d, half;
  logic                   spk_q, spk_d, done_q, done_d, busy_q, busy_d;
  function automatic logic [HALF_W-1:0] rom(input logic [2:0] i);
    case (i)
      3'd0:    rom = HALF_W'(95556);
      3'd1:    rom = HALF_W'(75843);
      3'd2:    rom = HALF_W'(63776);
      3'd4:    rom = HALF_W'(63776);
      3'd5:    rom = HALF_W'(75843);
      3'd6:    rom = HALF_W'(95556);
      default: rom = '0;
    endcase
  endfunction
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      beat_q  <= 1'b0;
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.in_beat_clock};
      dly_q   <= sync_q[SYNC_STAGES-1];
      beat_q  <= sync_q[SYNC_STAGES-1] & ~dly_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  // Speaker and counter default to cleared; only an uninterrupted PLAY cycle advances the tone.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    spk_d   = 1'b0;
    done_d  = 1'b0;
    half    = rom(idx_q);
    if (bus.in_stop) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE:      state_d = bus.in_start ? WAIT_BEAT : IDLE;
        WAIT_BEAT: begin
          state_d = beat_q ? PLAY : WAIT_BEAT;
          idx_d   = beat_q ? '0 : idx_q;
        end
        PLAY: begin
          if (beat_q) begin
            if (idx_q < 3'(LAST_NOTE)) begin
              idx_d = idx_q + 3'd1;
            end else begin
`ifdef TONE_PLAYER_LOOP_EN
              idx_d   = '0;
`else
              state_d = DONE;
`endif
              done_d  = 1'b1;
            end
          end else if (half != '0) begin
            cnt_d = (cnt_q == half - HALF_W'(1)) ? '0 : cnt_q + HALF_W'(1);
            spk_d = (cnt_q == half - HALF_W'(1)) ? ~spk_q : spk_q;
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == WAIT_BEAT) | (state_d == PLAY);
  end
  assign bus.out_speaker  = spk_q;
  assign bus.out_busy     = busy_q;
  assign bus.out_note_idx = idx_q;
  assign bus.out_done     = done_q;
endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: random-timed beat/start/stop stimulus checked every cycle against a note-level reference model.
module tb_tone_player;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tone_player_if bus();
  tone_player dut (.in_clock(clk), .in_reset_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference: modes 0 idle, 1 waiting for beat, 2 playing, 3 done; tone derived from time since note start.
  int rom [8] = '{95556, 75843, 63776, 0, 63776, 75843, 95556, 0};
  int m_mode = 0, m_idx = 0, m_start = 0, cyc = 0;
  logic m_done = 1'b0;
  bit hq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_start = 0; cyc = 0; m_done = 1'b0;
      hq = '{0, 0, 0, 0};
    end else begin
      bit ev;
      cyc++;
      hq.push_back(bus.in_beat_clock);
      if (hq.size() > 5) void'(hq.pop_front());
      ev = hq[hq.size()-4] & ~hq[hq.size()-5];
      m_done = 1'b0;
      if (bus.in_stop) begin
        m_mode = 0; m_idx = 0;
      end else if (m_mode == 0) begin
        if (bus.in_start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (ev) begin m_mode = 2; m_idx = 0; m_start = cyc; end
      end else if (m_mode == 2) begin
        if (ev && m_idx < 7) begin
          m_idx++; m_start = cyc;
        end else if (ev) begin
          m_done = 1'b1;
`ifdef TONE_PLAYER_LOOP_EN
          m_idx = 0; m_start = cyc;
`else
          m_mode = 3;
`endif
        end
      end else begin
        m_mode = 0; m_idx = 0;
      end
    end
  end
  function automatic logic [5:0] exp_outs();
    logic spk;
    spk = (m_mode == 2 && rom[m_idx] != 0) ? 1'(((cyc - m_start) / rom[m_idx]) % 2) : 1'b0;
    return {spk, (m_mode == 1 || m_mode == 2), 3'(m_idx), m_done};
  endfunction
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("outs", {bus.out_speaker, bus.out_busy, bus.out_note_idx, bus.out_done}, exp_outs());
  endtask
  task automatic steps(input int n);
    repeat (n) step();
  endtask
  task automatic beat();
    bus.in_beat_clock = 1'b1;
    steps($urandom_range(4, 8));
    bus.in_beat_clock = 1'b0;
    steps($urandom_range(4, 8));
  endtask
  initial begin
    int dn;
    bus.in_beat_clock = 1'b0;
    bus.in_start = 1'b0;
    bus.in_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", {bus.out_speaker, bus.out_busy, bus.out_note_idx, bus.out_done}, 0);
    rst_n = 1'b1;
    steps(3);
    bus.in_start = 1'b1; step(); bus.in_start = 1'b0;
    check("wait_busy", bus.out_busy, 1);
    beat();
    check("play_idx0", bus.out_note_idx, 0);
    check("play_busy", bus.out_busy, 1);
    steps(300);
    check("c5_quiet", bus.out_speaker, 0);
    beat(); beat(); beat();
    check("rest_idx", bus.out_note_idx, 3);
    steps(500);
    check("rest_quiet", bus.out_speaker, 0);
    beat();
    steps(63776 + 50);
    check("g5_toggle", bus.out_speaker, 1);
    beat();
    check("idx5", bus.out_note_idx, 5);
    bus.in_start = 1'b1; steps(2); bus.in_start = 1'b0;
    check("start_busy_idx", bus.out_note_idx, 5);
    beat();
    check("idx6", bus.out_note_idx, 6);
    beat();
    check("idx7", bus.out_note_idx, 7);
    dn = 0;
    bus.in_beat_clock = 1'b1;
    repeat (12) begin step(); dn += int'(bus.out_done); end
    bus.in_beat_clock = 1'b0;
    steps(6);
    check("done_count", dn, 1);
    check("end_idx", bus.out_note_idx, 0);
`ifdef TONE_PLAYER_LOOP_EN
    check("end_busy", bus.out_busy, 1);
`else
    check("end_busy", bus.out_busy, 0);
    beat(); beat();
    check("after_quiet", bus.out_speaker, 0);
`endif
    bus.in_stop = 1'b1; step(); bus.in_stop = 1'b0;
    bus.in_start = 1'b1; step(); bus.in_start = 1'b0;
    beat(); beat(); beat();
    check("abort_idx2", bus.out_note_idx, 2);
    dn = 0;
    bus.in_beat_clock = 1'b1;
    steps(3);
    bus.in_stop = 1'b1; step(); bus.in_stop = 1'b0;
    repeat (3) begin step(); dn += int'(bus.out_done); end
    bus.in_beat_clock = 1'b0;
    steps(4);
    check("abort_idx", bus.out_note_idx, 0);
    check("abort_busy", bus.out_busy, 0);
    check("abort_nodone", dn, 0);
    bus.in_start = 1'b1; bus.in_stop = 1'b1; step();
    bus.in_start = 1'b0; bus.in_stop = 1'b0; steps(2);
    check("start_stop", bus.out_busy, 0);
    bus.in_start = 1'b1; step(); bus.in_start = 1'b0;
    beat(); beat();
    steps(37);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {bus.out_speaker, bus.out_busy, bus.out_note_idx, bus.out_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    steps(2);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.in_beat_clock = ~bus.in_beat_clock;
      bus.in_start = ($urandom_range(0, 9) == 0);
      bus.in_stop  = ($urandom_range(0, 59) == 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
